// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the staged reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_ASSERT = 2'd1,
    HOLD        = 2'd2,
    RELEASE     = 2'd3
  } rst_seq_state_e;

  // Bits needed to hold the largest of the three phase lengths.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_seq_counter.sv
// Loadable down-counter with a registered zero flag; saturates at zero.
module rst_seq_counter #(
  parameter int           W       = 3,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         zero_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= RST_VAL;
      zero_q <= (RST_VAL == '0);
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
    end
  end

  assign zero = zero_q;

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset generator: delayed assert of all stages, hold, then in-order release.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int ASSERT_DLY  = 5,
  parameter int HOLD_CYCLES = 4,
  parameter int STAGE_GAP   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [NUM_STAGES-1:0] stage_rst_o,
  output logic                  busy,
  output logic                  done,
  output logic                  start_drop,
  output rst_seq_state_e        state_o
);

  if (NUM_STAGES < 1)  begin : g_bad_ns   $error("NUM_STAGES must be >= 1");  end
  if (ASSERT_DLY < 1)  begin : g_bad_ad   $error("ASSERT_DLY must be >= 1");  end
  if (HOLD_CYCLES < 1) begin : g_bad_hc   $error("HOLD_CYCLES must be >= 1"); end
  if (STAGE_GAP < 1)   begin : g_bad_sg   $error("STAGE_GAP must be >= 1");   end

  localparam int CW = cnt_width(ASSERT_DLY, HOLD_CYCLES, STAGE_GAP);
  localparam int IW = $clog2(NUM_STAGES + 1);

  // Phase counters count down to zero, and the transition happens on the edge that sees zero.
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] WAIT_LD  = CW'((ASSERT_DLY >= 2) ? ASSERT_DLY - 2 : 0);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_STAGES - 1);
  localparam logic [IW-1:0] NS_IDX   = IW'(NUM_STAGES);

  rst_seq_state_e        state_q, state_d;
  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  drop_q, drop_d;
  logic                  cnt_load;
  logic [CW-1:0]         cnt_val;
  logic                  cnt_zero;

  rst_seq_counter #(
    .W       (CW),
    .RST_VAL (HOLD_LD)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    drop_d   = start && (state_q != IDLE);
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d   = 1'b1;
          cnt_load = 1'b1;
          if (ASSERT_DLY == 1) begin
            state_d = HOLD;
            stage_d = '1;
            cnt_val = HOLD_LD;
          end else begin
            state_d = WAIT_ASSERT;
            cnt_val = WAIT_LD;
          end
        end
      end
      WAIT_ASSERT: begin
        if (cnt_zero) begin
          state_d  = HOLD;
          stage_d  = '1;
          cnt_load = 1'b1;
          cnt_val  = HOLD_LD;
        end
      end
      HOLD, RELEASE: begin
        if (cnt_zero) begin
          if (state_q == RELEASE && idx_q == NS_IDX) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            idx_d   = '0;
          end else begin
            // The final release loads zero so done follows one cycle later.
            state_d = RELEASE;
            for (int i = 0; i < NUM_STAGES; i++) begin
              if (IW'(i) == idx_q) stage_d[i] = 1'b0;
            end
            idx_d    = idx_q + IW'(1);
            cnt_load = 1'b1;
            cnt_val  = (idx_q == LAST_IDX) ? '0 : GAP_LD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HOLD;
      stage_q <= '1;
      idx_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign stage_rst_o = stage_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign start_drop  = drop_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer: default build plus a 1/1/1/1 build.
module tb_rst_sequencer;
  import rst_seq_pkg::*;

  typedef struct packed {
    int         smp;
    logic [3:0] stage;
    logic       busy;
    logic       done;
    logic       drop;
  } snap_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic           rst = 1'b1, start = 1'b0;
  logic [3:0]     stage_rst_o;
  logic           busy, done, start_drop;
  rst_seq_state_e state_o;

  logic           rst1 = 1'b1, start1 = 1'b0;
  logic [0:0]     stage1;
  logic           busy1, done1, drop1;
  rst_seq_state_e state1;

  rst_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stage_rst_o(stage_rst_o),
    .busy(busy), .done(done), .start_drop(start_drop), .state_o(state_o)
  );

  rst_sequencer #(.NUM_STAGES(1), .ASSERT_DLY(1), .HOLD_CYCLES(1), .STAGE_GAP(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .stage_rst_o(stage1),
    .busy(busy1), .done(done1), .start_drop(drop1), .state_o(state1)
  );

  snap_t exp_q[$];
  snap_t exp1_q[$];
  int    done_q[$];
  int    drop_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic wait_edge(input int n);
    while (cyc < n - 1) @(negedge clk);
  endtask

  function automatic void snap(input int s, input logic [3:0] st, input logic b,
                               input logic d, input logic dr);
    exp_q.push_back('{smp: s, stage: st, busy: b, done: d, drop: dr});
  endfunction

  function automatic void snap1(input int s, input logic st, input logic b, input logic d);
    exp1_q.push_back('{smp: s, stage: {3'b000, st}, busy: b, done: d, drop: 1'b0});
  endfunction

  // Power-on release after rst held for edges b+1..b+3.
  function automatic void push_por(input int b);
    snap(b + 2, 4'hF, 1, 0, 0);
    snap(b + 4, 4'hF, 1, 0, 0);
    snap(b + 7, 4'hF, 1, 0, 0);
    snap(b + 8, 4'hE, 1, 0, 0);
    snap(b + 9, 4'hE, 1, 0, 0);
    snap(b + 10, 4'hC, 1, 0, 0);
    snap(b + 12, 4'h8, 1, 0, 0);
    snap(b + 14, 4'h0, 1, 0, 0);
    snap(b + 15, 4'h0, 0, 1, 0);
    snap(b + 16, 4'h0, 0, 0, 0);
    done_q.push_back(b + 15);
  endfunction

  // Sequence triggered by start sampled at edge b+30.
  function automatic void push_trig(input int b, input logic drop38);
    snap(b + 31, 4'h0, 1, 0, 0);
    snap(b + 34, 4'h0, 1, 0, 0);
    snap(b + 35, 4'hF, 1, 0, 0);
    snap(b + 38, 4'hF, 1, 0, drop38);
    snap(b + 39, 4'hE, 1, 0, 0);
    snap(b + 41, 4'hC, 1, 0, 0);
    snap(b + 43, 4'h8, 1, 0, 0);
    snap(b + 45, 4'h0, 1, 0, 0);
    snap(b + 46, 4'h0, 0, 1, 0);
    snap(b + 47, 4'h0, 0, 0, 0);
    done_q.push_back(b + 46);
  endfunction

  task automatic do_reset(input int b);
    wait_edge(b + 1);
    rst = 1'b1;
    wait_edge(b + 4);
    rst = 1'b0;
  endtask

  task automatic pulse_start(input int e);
    wait_edge(e);
    start = 1'b1;
    wait_edge(e + 1);
    start = 1'b0;
  endtask

  // Monitor: compares snapshots on their sample and pops event queues whenever done/start_drop fire.
  always @(negedge clk) begin
    int    s;
    snap_t e;
    int    ev;
    s = cyc + 1;
    while (exp_q.size() > 0 && exp_q[0].smp <= s) begin
      e = exp_q.pop_front();
      n_checks++;
      if (e.smp != s || {stage_rst_o, busy, done, start_drop} !== {e.stage, e.busy, e.done, e.drop}) begin
        n_fail++;
        $display("FAIL snap@%0d: got stage=%h busy=%b done=%b drop=%b, want stage=%h busy=%b done=%b drop=%b",
                 e.smp, stage_rst_o, busy, done, start_drop, e.stage, e.busy, e.done, e.drop);
      end
    end
    if (done === 1'b1) begin
      n_checks++;
      if (done_q.size() == 0) begin
        n_fail++;
        $display("FAIL done_event: unexpected done at sample %0d", s);
      end else begin
        ev = done_q.pop_front();
        if (ev != s) begin
          n_fail++;
          $display("FAIL done_event: got sample %0d, want %0d", s, ev);
        end
      end
      n_checks++;
      if (state_o !== IDLE) begin
        n_fail++;
        $display("FAIL done_state: got %0d, want IDLE at sample %0d", state_o, s);
      end
    end
    if (start_drop === 1'b1) begin
      n_checks++;
      if (drop_q.size() == 0) begin
        n_fail++;
        $display("FAIL drop_event: unexpected start_drop at sample %0d", s);
      end else begin
        ev = drop_q.pop_front();
        if (ev != s) begin
          n_fail++;
          $display("FAIL drop_event: got sample %0d, want %0d", s, ev);
        end
      end
    end
    while (exp1_q.size() > 0 && exp1_q[0].smp <= s) begin
      e = exp1_q.pop_front();
      n_checks++;
      if (e.smp != s || {3'b000, stage1, busy1, done1, drop1} !== {e.stage, e.busy, e.done, e.drop}) begin
        n_fail++;
        $display("FAIL sweep@%0d: got stage=%b busy=%b done=%b drop=%b, want stage=%b busy=%b done=%b drop=0",
                 e.smp, stage1, busy1, done1, drop1, e.stage[0], e.busy, e.done);
      end
    end
  end

  // Single-stage build: POR through edge 3, start at edge 10.
  initial begin
    snap1(2, 1, 1, 0);
    snap1(4, 1, 1, 0);
    snap1(5, 0, 1, 0);
    snap1(6, 0, 0, 1);
    snap1(11, 1, 1, 0);
    snap1(12, 0, 1, 0);
    snap1(13, 0, 0, 1);
    snap1(14, 0, 0, 0);
    wait_edge(4);
    rst1 = 1'b0;
    wait_edge(10);
    start1 = 1'b1;
    wait_edge(11);
    start1 = 1'b0;
  end

  initial begin
    int b;
    // Power-on release followed by a single triggered sequence.
    b = 0;
    push_por(b);
    push_trig(b, 1'b0);
    do_reset(b);
    pulse_start(b + 30);
    wait_edge(b + 70);

    // Second start while busy is dropped without disturbing timing.
    b = 100;
    push_por(b);
    push_trig(b, 1'b1);
    drop_q.push_back(b + 38);
    do_reset(b);
    pulse_start(b + 30);
    pulse_start(b + 37);
    wait_edge(b + 70);

    // Start held high: drops every busy cycle, re-trigger on the done cycle.
    b = 200;
    push_por(b);
    snap(b + 31, 4'h0, 1, 0, 0);
    snap(b + 32, 4'h0, 1, 0, 1);
    snap(b + 35, 4'hF, 1, 0, 1);
    snap(b + 39, 4'hE, 1, 0, 1);
    snap(b + 45, 4'h0, 1, 0, 1);
    snap(b + 46, 4'h0, 0, 1, 1);
    snap(b + 47, 4'h0, 1, 0, 0);
    snap(b + 50, 4'h0, 1, 0, 0);
    snap(b + 51, 4'hF, 1, 0, 0);
    snap(b + 55, 4'hE, 1, 0, 0);
    snap(b + 61, 4'h0, 1, 0, 0);
    snap(b + 62, 4'h0, 0, 1, 0);
    done_q.push_back(b + 46);
    done_q.push_back(b + 62);
    for (int k = 32; k <= 46; k++) drop_q.push_back(b + k);
    do_reset(b);
    wait_edge(b + 30);
    start = 1'b1;
    wait_edge(b + 47);
    start = 1'b0;
    wait_edge(b + 80);

    // rst at edge b+40 aborts the sequence and restarts the power-on release.
    b = 300;
    push_por(b);
    snap(b + 31, 4'h0, 1, 0, 0);
    snap(b + 35, 4'hF, 1, 0, 0);
    snap(b + 39, 4'hE, 1, 0, 0);
    snap(b + 40, 4'hE, 1, 0, 0);
    snap(b + 41, 4'hF, 1, 0, 0);
    snap(b + 44, 4'hF, 1, 0, 0);
    snap(b + 45, 4'hE, 1, 0, 0);
    snap(b + 47, 4'hC, 1, 0, 0);
    snap(b + 49, 4'h8, 1, 0, 0);
    snap(b + 51, 4'h0, 1, 0, 0);
    snap(b + 52, 4'h0, 0, 1, 0);
    snap(b + 53, 4'h0, 0, 0, 0);
    done_q.push_back(b + 52);
    do_reset(b);
    pulse_start(b + 30);
    wait_edge(b + 40);
    rst = 1'b1;
    wait_edge(b + 41);
    rst = 1'b0;
    wait_edge(b + 70);

    n_checks++;
    if (exp_q.size() != 0 || exp1_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_snaps: got %0d/%0d pending, want 0/0", exp_q.size(), exp1_q.size());
    end
    n_checks++;
    if (done_q.size() != 0 || drop_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_events: got done=%0d drop=%0d pending, want 0/0", done_q.size(), drop_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout at cycle %0d, want completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
